// File: rtl/awg_play_ctrl.sv
// Arbitrary-waveform playback controller: byte-command parser, trigger synchronizer and sample-address sequencer.
// Define AWG_PLAY_LOOP_EN to build the multi-pass loop counter (LOOPS == 0 repeats until ABORT).
module awg_play_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk100,
  input  logic              rstn,
  input  logic              cmd_tvalid,
  output logic              cmd_tready,
  input  logic [7:0]        cmd_tdata,
  input  logic              trigger,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              armed,
  output logic              busy,
  output logic              done_pulse,
  output logic              err_latched
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PLAY} state_t;
  typedef enum logic [1:0] {PH_OPCODE, PH_LO, PH_HI} phase_t;

  localparam logic [7:0] OP_SET_START = 8'h01;
  localparam logic [7:0] OP_SET_LEN   = 8'h02;
  localparam logic [7:0] OP_SET_LOOPS = 8'h03;
  localparam logic [7:0] OP_ARM       = 8'h04;
  localparam logic [7:0] OP_FORCE     = 8'h05;
  localparam logic [7:0] OP_ABORT     = 8'h06;

  state_t            state, state_next;
  phase_t            phase;
  logic [7:0]        opcode_q, lo_q;
  logic [ADDR_W-1:0] sh_start, sh_len, act_start, act_len, idx;
  logic              cmd_fire, op_arm, op_force, op_abort, op_bad;
  logic              trig_s1, trig_s2, trig_s3, trig_edge;
  logic              load_active, arm_err, go_play, pass_end, last_pass, run_end;

`ifdef AWG_PLAY_LOOP_EN
  logic [15:0] sh_loops, loops_left;
  assign last_pass = (loops_left == 16'd1);
`else
  assign last_pass = 1'b1;
`endif

  assign cmd_fire  = cmd_tvalid & cmd_tready;
  assign trig_edge = trig_s2 & ~trig_s3;
  assign armed     = (state == ST_ARMED);
  assign busy      = (state == ST_PLAY);
  assign rd_en     = (state == ST_PLAY);

  // Single-byte opcodes act the cycle they are accepted; payload opcodes only start a frame
  always_comb begin
    op_arm   = 1'b0;
    op_force = 1'b0;
    op_abort = 1'b0;
    op_bad   = 1'b0;
    if (cmd_fire && phase == PH_OPCODE) begin
      case (cmd_tdata)
        OP_SET_START, OP_SET_LEN, OP_SET_LOOPS: ;
        OP_ARM:   op_arm   = 1'b1;
        OP_FORCE: op_force = 1'b1;
        OP_ABORT: op_abort = 1'b1;
        default:  op_bad   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      phase    <= PH_OPCODE;
      opcode_q <= '0;
      lo_q     <= '0;
      sh_start <= '0;
      sh_len   <= '0;
`ifdef AWG_PLAY_LOOP_EN
      sh_loops <= 16'd1;
`endif
    end else if (cmd_fire) begin
      case (phase)
        PH_OPCODE: begin
          if (cmd_tdata == OP_SET_START || cmd_tdata == OP_SET_LEN || cmd_tdata == OP_SET_LOOPS) begin
            opcode_q <= cmd_tdata;
            phase    <= PH_LO;
          end
        end
        PH_LO: begin
          lo_q  <= cmd_tdata;
          phase <= PH_HI;
        end
        default: begin
          // Upper payload bits beyond the address width are dropped by the size cast
          if (opcode_q == OP_SET_START) sh_start <= ADDR_W'({cmd_tdata, lo_q});
          if (opcode_q == OP_SET_LEN)   sh_len   <= ADDR_W'({cmd_tdata, lo_q});
`ifdef AWG_PLAY_LOOP_EN
          if (opcode_q == OP_SET_LOOPS) sh_loops <= {cmd_tdata, lo_q};
`endif
          phase <= PH_OPCODE;
        end
      endcase
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_s3 <= 1'b0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  // ABORT is checked ahead of trigger/FORCE and end-of-run so it always wins
  always_comb begin
    state_next  = state;
    load_active = 1'b0;
    arm_err     = 1'b0;
    go_play     = 1'b0;
    pass_end    = 1'b0;
    run_end     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op_arm) begin
          if (sh_len != '0) begin
            load_active = 1'b1;
            state_next  = ST_ARMED;
          end else begin
            arm_err = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (op_abort) begin
          state_next = ST_IDLE;
        end else if (op_force || trig_edge) begin
          go_play    = 1'b1;
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (op_abort) begin
          state_next = ST_IDLE;
        end else if (idx == act_len - ADDR_W'(1)) begin
          pass_end = 1'b1;
          if (last_pass) begin
            run_end    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // rd_addr only moves while playing, so it holds its last value once rd_en drops
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      cmd_tready  <= 1'b0;
      err_latched <= 1'b0;
      done_pulse  <= 1'b0;
      act_start   <= '0;
      act_len     <= '0;
      idx         <= '0;
      rd_addr     <= '0;
`ifdef AWG_PLAY_LOOP_EN
      loops_left  <= 16'd1;
`endif
    end else begin
      cmd_tready  <= 1'b1;
      err_latched <= err_latched | op_bad | arm_err;
      done_pulse  <= run_end;
      if (load_active) begin
        act_start <= sh_start;
        act_len   <= sh_len;
`ifdef AWG_PLAY_LOOP_EN
        loops_left <= sh_loops;
`endif
      end
      if (go_play || (pass_end && !run_end)) begin
        idx     <= '0;
        rd_addr <= act_start;
`ifdef AWG_PLAY_LOOP_EN
        if (pass_end && loops_left != 16'd0) loops_left <= loops_left - 16'd1;
`endif
      end else if (state == ST_PLAY && !op_abort && !run_end) begin
        idx     <= idx + ADDR_W'(1);
        rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

endmodule
